xreg_feed_ctrl: RTL and testbench

- Sequencer for a bank of LANES x_reg parallel shift registers that feed the systolic multiplier array.
- Accepts a command giving the operand length.
- Loads LANES*len bytes from an input stream into the registers using indexed writes.
- Drains the lanes with a one-cycle-per-lane skew, so operands enter the array diagonally, then pulses done.

---
 rtl/fm_pkg.sv | 22 ++
 rtl/xreg_skew_gen.sv | 20 ++
 rtl/xreg_feed_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_xreg_feed_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// fm_pkg: shared types and default sizing for the x_reg feed controller.
package fm_pkg;

   localparam int LANES_DEF = 4;
   localparam int DEPTH_DEF = 7;
   localparam int DW_DEF    = 8;
   localparam int IDXW_DEF  = 5;
   localparam int LENW_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } feed_state_t;

   // Counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/xreg_skew_gen.sv
// xreg_skew_gen: diagonal enable mask for draining the lanes, lane k active for t in [k, k+len).
module xreg_skew_gen #(
   parameter int LANES = 4,
   parameter int TW    = 4,
   parameter int LW    = 3
) (
   input  logic [TW-1:0]    t,
   input  logic [LW-1:0]    len,
   output logic [LANES-1:0] en
);

   // Lane k starts k cycles late and stays on for len cycles.
   always_comb begin
      en = '0;
      for (int k = 0; k < LANES; k++) begin
         en[k] = (int'(t) >= k) && (int'(t) < k + int'(len));
      end
   end

endmodule

// File: rtl/xreg_feed_ctrl.sv
// xreg_feed_ctrl: loads LANES*len operand bytes into the x_reg bank by indexed writes, then
// drains the lanes with a one-cycle-per-lane skew and pulses done.
// Build option XREG_ZERO_PAD_EN: after each lane's last byte, zero-fill idx len..DEPTH-1.
module xreg_feed_ctrl
   import fm_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF,
   parameter int IDXW  = IDXW_DEF,
   parameter int LENW  = LENW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LENW-1:0]  cmd_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic [LANES-1:0] xr_en,
   output logic             xr_write,
   output logic [IDXW-1:0]  xr_idx,
   output logic [DW-1:0]    xr_din,
   output logic [LANES-1:0] lane_vld,
   output logic             busy,
   output logic             done
);

   localparam int LW  = clog2_min1(DEPTH + 1);      // len 0..DEPTH
   localparam int IW  = clog2_min1(DEPTH);          // idx 0..DEPTH-1
   localparam int LCW = clog2_min1(LANES);          // lane 0..LANES-1
   localparam int TW  = clog2_min1(DEPTH + LANES);  // t 0..len+LANES-2

   feed_state_t      state_q, state_d;
   logic [LW-1:0]    len_q, len_d;
   logic [LCW-1:0]   lane_cnt_q, lane_cnt_d;
   logic [IW-1:0]    idx_cnt_q, idx_cnt_d;
   logic [TW-1:0]    t_q, t_d;

   logic [LANES-1:0] xr_en_q, xr_en_d;
   logic             xr_write_q, xr_write_d;
   logic [IDXW-1:0]  xr_idx_q, xr_idx_d;
   logic [DW-1:0]    xr_din_q, xr_din_d;
   logic [LANES-1:0] lane_vld_q;
   logic             busy_q;
   logic             done_q;

`ifdef XREG_ZERO_PAD_EN
   logic             pad_q, pad_d;
`endif

   logic [LW-1:0]    len_clamp;
   logic [LANES-1:0] skew_en;
   logic             hs;
   logic             idx_last_len;
   logic             lane_last;
   logic             t_last;

   assign len_clamp = (int'(cmd_len) > DEPTH) ? LW'(DEPTH) : LW'(cmd_len);

   assign cmd_ready = (state_q == IDLE);
`ifdef XREG_ZERO_PAD_EN
   assign in_ready  = (state_q == LOAD) && !pad_q;
`else
   assign in_ready  = (state_q == LOAD);
`endif
   assign hs = in_valid && in_ready;

   assign idx_last_len = (int'(idx_cnt_q) == int'(len_q) - 1);
   assign lane_last    = (int'(lane_cnt_q) == LANES - 1);
   assign t_last       = (int'(t_q) == int'(len_q) + LANES - 2);

   xreg_skew_gen #(
      .LANES (LANES),
      .TW    (TW),
      .LW    (LW)
   ) u_skew (
      .t   (t_q),
      .len (len_q),
      .en  (skew_en)
   );

   // Next-state, counters and the next value of every registered x_reg strobe.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      lane_cnt_d = lane_cnt_q;
      idx_cnt_d  = idx_cnt_q;
      t_d        = t_q;
      xr_en_d    = '0;
      xr_write_d = 1'b0;
      xr_idx_d   = '0;
      xr_din_d   = '0;
`ifdef XREG_ZERO_PAD_EN
      pad_d      = pad_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               len_d      = len_clamp;
               lane_cnt_d = '0;
               idx_cnt_d  = '0;
               t_d        = '0;
               state_d    = (len_clamp == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
`ifdef XREG_ZERO_PAD_EN
            if (pad_q) begin
               // Zero-fill the tail of the current lane so stale data never drains.
               xr_en_d    = LANES'(1) << lane_cnt_q;
               xr_write_d = 1'b1;
               xr_idx_d   = IDXW'(idx_cnt_q);
               if (int'(idx_cnt_q) == DEPTH - 1) begin
                  idx_cnt_d = '0;
                  pad_d     = 1'b0;
                  if (lane_last) begin
                     state_d = DRAIN;
                     t_d     = '0;
                  end else begin
                     lane_cnt_d = lane_cnt_q + LCW'(1);
                  end
               end else begin
                  idx_cnt_d = idx_cnt_q + IW'(1);
               end
            end else
`endif
            if (hs) begin
               xr_en_d    = LANES'(1) << lane_cnt_q;
               xr_write_d = 1'b1;
               xr_idx_d   = IDXW'(idx_cnt_q);
               xr_din_d   = in_data;
               if (idx_last_len) begin
`ifdef XREG_ZERO_PAD_EN
                  if (int'(len_q) < DEPTH) begin
                     idx_cnt_d = idx_cnt_q + IW'(1);
                     pad_d     = 1'b1;
                  end else
`endif
                  begin
                     idx_cnt_d = '0;
                     if (lane_last) begin
                        state_d = DRAIN;
                        t_d     = '0;
                     end else begin
                        lane_cnt_d = lane_cnt_q + LCW'(1);
                     end
                  end
               end else begin
                  idx_cnt_d = idx_cnt_q + IW'(1);
               end
            end
         end
         DRAIN: begin
            xr_en_d = skew_en;
            if (t_last) begin
               state_d = DONE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers; reset abandons any command in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         lane_cnt_q <= '0;
         idx_cnt_q  <= '0;
         t_q        <= '0;
`ifdef XREG_ZERO_PAD_EN
         pad_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         lane_cnt_q <= lane_cnt_d;
         idx_cnt_q  <= idx_cnt_d;
         t_q        <= t_d;
`ifdef XREG_ZERO_PAD_EN
         pad_q      <= pad_d;
`endif
      end
   end

   // Registered outputs; lane_vld follows drain enables by one cycle to match x_reg dout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xr_en_q    <= '0;
         xr_write_q <= 1'b0;
         xr_idx_q   <= '0;
         xr_din_q   <= '0;
         lane_vld_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         xr_en_q    <= xr_en_d;
         xr_write_q <= xr_write_d;
         xr_idx_q   <= xr_idx_d;
         xr_din_q   <= xr_din_d;
         lane_vld_q <= xr_write_q ? '0 : xr_en_q;
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_q == DONE);
      end
   end

   assign xr_en    = xr_en_q;
   assign xr_write = xr_write_q;
   assign xr_idx   = xr_idx_q;
   assign xr_din   = xr_din_q;
   assign lane_vld = lane_vld_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_xreg_feed_ctrl.sv
// tb_xreg_feed_ctrl: directed checks of load, skewed drain, zero-length, full-length, reset
// abandonment and (when XREG_ZERO_PAD_EN is defined) tail padding.
module tb_xreg_feed_ctrl;

   localparam int LANES = 4;
   localparam int DEPTH = 7;
`ifdef XREG_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_len;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [3:0] xr_en;
   logic       xr_write;
   logic [4:0] xr_idx;
   logic [7:0] xr_din;
   logic [3:0] lane_vld;
   logic       busy;
   logic       done;

   int total;
   int bad;
   int load_cycles;
   int en_cycles;
   logic [3:0] seen_en [0:15];

   xreg_feed_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .xr_en     (xr_en),
      .xr_write  (xr_write),
      .xr_idx    (xr_idx),
      .xr_din    (xr_din),
      .lane_vld  (lane_vld),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected drain mask: lane k on for k <= c < k+l.
   function automatic logic [3:0] skew(input int c, input int l);
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < LANES; k++) begin
         if (c >= k && c < k + l) m[k] = 1'b1;
      end
      return m;
   endfunction

   // Drive one cycle of input, then check the registered outputs at the next falling edge.
   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] en,
                        input logic wr, input logic [4:0] idx, input logic [7:0] din,
                        input logic [3:0] vld, input logic dn);
      in_valid = v;
      in_data  = d;
      @(negedge clk);
      chk("xr_en", xr_en, en);
      chk("xr_write", xr_write, wr);
      if (wr) begin
         chk("xr_idx", xr_idx, idx);
         chk("xr_din", xr_din, din);
      end
      chk("lane_vld", lane_vld, vld);
      chk("done", done, dn);
   endtask

   task automatic issue_cmd(input int len);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_len   = 3'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("busy_after_cmd", busy, 1);
      chk("in_ready_after_cmd", in_ready, (len != 0) ? 1 : 0);
      chk("done_after_cmd", done, 0);
   endtask

   task automatic load(input int l, input int base, input bit gap);
      logic [7:0] d;
      load_cycles = 0;
      for (int ln = 0; ln < LANES; ln++) begin
         for (int i = 0; i < l; i++) begin
            if (gap) begin
               chk("in_ready_gap", in_ready, 1);
               drive(1'b0, 8'h00, 4'b0000, 1'b0, 5'd0, 8'h00, 4'b0000, 1'b0);
               load_cycles++;
            end
            chk("in_ready_load", in_ready, 1);
            d = 8'(base + ln * l + i);
            drive(1'b1, d, 4'(1 << ln), 1'b1, 5'(i), d, 4'b0000, 1'b0);
            load_cycles++;
         end
         if (PAD && l < DEPTH) begin
            for (int j = l; j < DEPTH; j++) begin
               chk("in_ready_pad", in_ready, 0);
               drive(1'b0, 8'h00, 4'(1 << ln), 1'b1, 5'(j), 8'h00, 4'b0000, 1'b0);
               load_cycles++;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int l);
      en_cycles = 0;
      chk("in_ready_drain", in_ready, 0);
      for (int c = 0; c <= l + LANES - 1; c++) begin
         drive(1'b0, 8'h00, skew(c, l), 1'b0, 5'd0, 8'h00, skew(c - 1, l),
               (c == l + LANES - 1) ? 1'b1 : 1'b0);
         seen_en[c] = xr_en;
         if (xr_en != 4'b0000) en_cycles++;
      end
      @(negedge clk);
      chk("done_cleared", done, 0);
      chk("lane_vld_cleared", lane_vld, 4'b0000);
      chk("cmd_ready_end", cmd_ready, 1);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = 3'd0;
      in_valid  = 1'b0;
      in_data   = 8'h00;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_xr_en", xr_en, 4'b0000);
      chk("rst_xr_write", xr_write, 0);
      chk("rst_xr_idx", xr_idx, 5'd0);
      chk("rst_xr_din", xr_din, 8'h00);
      chk("rst_lane_vld", lane_vld, 4'b0000);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      // len=3, bytes 01..0C, back-to-back
      issue_cmd(3);
      load(3, 1, 1'b0);
      chk("load_cycles_len3", load_cycles, PAD ? 28 : 12);
      drain(3);
      chk("drain_t0", seen_en[0], 4'b0001);
      chk("drain_t1", seen_en[1], 4'b0011);
      chk("drain_t2", seen_en[2], 4'b0111);
      chk("drain_t3", seen_en[3], 4'b1110);
      chk("drain_t4", seen_en[4], 4'b1100);
      chk("drain_t5", seen_en[5], 4'b1000);
      chk("drain_cycles_len3", en_cycles, 6);

      // Same command with in_valid toggling; load takes twice as long
      issue_cmd(3);
      load(3, 'h21, 1'b1);
      chk("load_cycles_gap", load_cycles, PAD ? 40 : 24);
      drain(3);

      // len=0: no writes, done two cycles after the handshake
      issue_cmd(0);
      chk("len0_xr_en", xr_en, 4'b0000);
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_xr_en2", xr_en, 4'b0000);
      chk("len0_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      chk("len0_done_clr", done, 0);

      // len=7 == DEPTH: drain lasts 10 cycles
      issue_cmd(7);
      load(7, 'h40, 1'b0);
      chk("load_cycles_len7", load_cycles, 28);
      drain(7);
      chk("drain_cycles_len7", en_cycles, 10);

      // Reset after 3 bytes abandons the command
      issue_cmd(3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h70 + i), 4'b0001, 1'b1, 5'(i), 8'(8'h70 + i), 4'b0000, 1'b0);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_xr_en", xr_en, 4'b0000);
      chk("arst_busy", busy, 0);
      chk("arst_in_ready", in_ready, 0);
      @(negedge clk);
      chk("arst_done", done, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_done", done, 0);
         chk("post_rst_xr_en", xr_en, 4'b0000);
      end
      issue_cmd(2);
      load(2, 'h81, 1'b0);
      chk("load_cycles_len2", load_cycles, PAD ? 28 : 8);
      drain(2);

      // len=5: padding writes idx 5,6 only when the pad option is built in
      issue_cmd(5);
      load(5, 'h90, 1'b0);
      chk("load_cycles_len5", load_cycles, PAD ? 28 : 20);
      drain(5);
      chk("drain_cycles_len5", en_cycles, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
